// File: rtl/system_peripheral_pkg.sv
// Register map, CTRL field layout and boot FSM encoding for the system peripherals.
// Bus addresses are word indices into the register map.
package SystemPeripheral_Pkg;

    localparam int REG_AW = 8;

    typedef struct packed {
        logic [REG_AW-1:0] raddr;
        logic [REG_AW-1:0] waddr;
        logic [31:0]       wdata;
    } sys_peripheral_t;

    localparam logic [REG_AW-1:0] REG_CTRL     = 8'd0;
    localparam logic [REG_AW-1:0] REG_STR_ADDR = 8'd1;
    localparam logic [REG_AW-1:0] REG_STR_DATA = 8'd2;
    localparam logic [REG_AW-1:0] REG_TIMEOUT  = 8'd3;

    localparam int CTRL_DL_BIT    = 0;
    localparam int CTRL_RUN_BIT   = 1;
    localparam int CTRL_STATE_LSB = 2;
    localparam int CTRL_ERR_BIT   = 4;
    localparam int CTRL_IMG_LSB   = 8;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } boot_state_e;

endpackage

// File: rtl/utils_pkg.sv
// Shared bus helper types used across the peripheral slice.
// Each peripheral gets one read strobe and one write strobe.
package Utils_Pkg;

    typedef struct packed {
        logic ren;
        logic wen;
    } sel_t;

endpackage

// File: rtl/boot_str_rom.sv
// Asynchronous-read byte ROM holding the boot banner string.
// Contents arrive as one packed image, byte i at bits [8*i +: 8].
module boot_str_rom #(
    parameter int                     STR_DEPTH  = 64,
    parameter logic [8*STR_DEPTH-1:0] INIT_IMAGE = '0
) (
    input  logic [$clog2(STR_DEPTH)-1:0] addr,
    output logic [7:0]                   data
);

    logic [7:0] rom [STR_DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < STR_DEPTH; gi++) begin : g_rom
            assign rom[gi] = INIT_IMAGE[gi*8 +: 8];
        end
    endgenerate

    assign data = rom[addr];

endmodule

// File: rtl/harvard_boot_ctrl.sv
// Boot controller: runs image 0 (bootloader) until a keyed CTRL write or the
// auto-boot timer selects an application image, then switches the instruction mux.
module harvard_boot_ctrl
    import Utils_Pkg::*;
    import SystemPeripheral_Pkg::*;
#(
    parameter int                     NUM_IMAGES     = 2,
    parameter int                     STR_DEPTH      = 64,
    parameter logic [7:0]             BOOT_KEY       = 8'hF0,
    parameter int                     ARM_DELAY      = 1,
    parameter logic [31:0]            TIMEOUT_CYCLES = 32'd50_000_000,
    parameter int                     DEFAULT_IMAGE  = 1,
    parameter logic [8*STR_DEPTH-1:0] STR_INIT       = '0
) (
    input  logic                         hb_clk,
    input  logic                         rst_sync,
    input  logic [NUM_IMAGES-1:0][31:0]  image_instruction,
    output logic [31:0]                  instruction,
    input  sys_peripheral_t              sys_share,
    input  sel_t                         sel,
    output logic [31:0]                  rdata,
    input  logic                         download_mode,
    output logic                         run_mode
);

    localparam int              STR_AW   = $clog2(STR_DEPTH);
    localparam int              IMG_W    = $clog2(NUM_IMAGES);
    localparam logic [IMG_W-1:0] DEF_IMG = IMG_W'(DEFAULT_IMAGE);
    localparam logic [3:0]      ARM_LAST = 4'(ARM_DELAY - 1);

    boot_state_e       state_q, state_d;
    logic [IMG_W-1:0]  img_q, img_d;
    logic              err_q, err_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [3:0]        arm_q, arm_d;
    logic [STR_AW-1:0] str_q, str_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              ctrl_wr, key_wr, img_ok, auto_boot, str_wr, str_rd;
    logic [7:0]        req_img;
    logic [STR_AW-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic [31:0]       ctrl_word;
    logic              unused_wdata;

    assign ctrl_wr   = sel.wen && (sys_share.waddr == REG_CTRL);
    assign key_wr    = ctrl_wr && (sys_share.wdata[7:0] == BOOT_KEY) && (state_q == BOOT);
    assign req_img   = sys_share.wdata[15:8];
    assign img_ok    = (req_img != 8'd0) && ({24'd0, req_img} < 32'(NUM_IMAGES));
    // Auto-boot is judged on the counter alone so a same-cycle key write can still win.
    assign auto_boot = (state_q == BOOT) && !download_mode && (TIMEOUT_CYCLES != 32'd0)
                       && (cnt_q == 32'd1);

    assign str_wr    = sel.wen && (sys_share.waddr == REG_STR_ADDR);
    assign str_rd    = sel.ren && (sys_share.raddr == REG_STR_DATA);
    assign rom_addr  = str_wr ? sys_share.wdata[STR_AW-1:0] : str_q;
    assign unused_wdata = ^sys_share.wdata[31:16];

    boot_str_rom #(
        .STR_DEPTH  (STR_DEPTH),
        .INIT_IMAGE (STR_INIT)
    ) u_str_rom (
        .addr (rom_addr),
        .data (rom_data)
    );

    always_comb begin
        state_d = state_q;
        img_d   = img_q;
        err_d   = err_q;
        arm_d   = arm_q;
        cnt_d   = cnt_q;
        case (state_q)
            BOOT: begin
                if (key_wr && img_ok) begin
                    state_d = ARMED;
                    img_d   = req_img[IMG_W-1:0];
                    arm_d   = ARM_LAST;
                end else if (auto_boot) begin
                    state_d = ARMED;
                    img_d   = DEF_IMG;
                    arm_d   = ARM_LAST;
                end
                if (key_wr && !img_ok) begin
                    err_d = 1'b1;
                end
                if (download_mode || ctrl_wr) begin
                    cnt_d = TIMEOUT_CYCLES;
                end else if (TIMEOUT_CYCLES != 32'd0) begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            ARMED: begin
                if (arm_q == 4'd0) begin
                    state_d = RUN;
                end else begin
                    arm_d = arm_q - 4'd1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        ctrl_word                          = '0;
        ctrl_word[CTRL_IMG_LSB +: 8]       = 8'(img_q);
        ctrl_word[CTRL_ERR_BIT]            = err_q;
        ctrl_word[CTRL_STATE_LSB +: 2]     = state_q;
        ctrl_word[CTRL_RUN_BIT]            = run_mode;
        ctrl_word[CTRL_DL_BIT]             = download_mode;

        str_d   = str_q;
        rdata_d = rdata_q;
        if (str_rd) begin
            str_d = rom_addr + 1'b1;
        end else if (str_wr) begin
            str_d = sys_share.wdata[STR_AW-1:0];
        end
        if (sel.ren) begin
            case (sys_share.raddr)
                REG_CTRL:     rdata_d = ctrl_word;
                REG_STR_ADDR: rdata_d = 32'(str_q);
                REG_STR_DATA: rdata_d = {24'd0, rom_data};
                REG_TIMEOUT:  rdata_d = cnt_q;
                default:      rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge hb_clk or posedge rst_sync) begin
        if (rst_sync) begin
            state_q <= BOOT;
            img_q   <= '0;
            err_q   <= 1'b0;
            arm_q   <= '0;
            cnt_q   <= TIMEOUT_CYCLES;
            str_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            img_q   <= img_d;
            err_q   <= err_d;
            arm_q   <= arm_d;
            cnt_q   <= cnt_d;
            str_q   <= str_d;
            rdata_q <= rdata_d;
        end
    end

    assign run_mode    = (state_q == RUN);
    assign instruction = run_mode ? image_instruction[img_q] : image_instruction[0];
    assign rdata       = rdata_q;

endmodule
